freq_bcd_convert: RTL and testbench



---
 rtl/freq_bcd_convert_if.sv | 36 +++
 rtl/freq_bcd_convert.sv | 164 ++++++++++++++++
 tb/tb_freq_bcd_convert.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/freq_bcd_convert_if.sv
// freq_bcd_convert_if
//   Bundles the frequency result bus and the BCD readout it is converted to.
//   master : the frequency counter side; drives data_fx and observes the readout.
//   slave  : the BCD converter; samples data_fx and drives the readout.
// Signals:
//   data_fx   [DW-1:0]       frequency in Hz, quasi-static, foreign clock domain
//   bcd_out   [4*DIGITS-1:0] packed BCD, digit 0 (units) in [3:0]
//   digit_cnt [2:0]          number of significant digits, 1..DIGITS
//   bcd_valid                one-cycle pulse when bcd_out/digit_cnt update
//   busy                     high while a conversion is in progress
interface freq_bcd_convert_if #(
  parameter int DW     = 20,
  parameter int DIGITS = 7
);
  logic [DW-1:0]       data_fx;
  logic [4*DIGITS-1:0] bcd_out;
  logic [2:0]          digit_cnt;
  logic                bcd_valid;
  logic                busy;

  modport master (
    output data_fx,
    input  bcd_out,
    input  digit_cnt,
    input  bcd_valid,
    input  busy
  );

  modport slave (
    input  data_fx,
    output bcd_out,
    output digit_cnt,
    output bcd_valid,
    output busy
  );
endinterface

// File: rtl/freq_bcd_convert.sv
// freq_bcd_convert
//   Converts the 20-bit frequency result of the counter into packed BCD with a
//   significant-digit count for the on-screen readout. The result bus comes
//   from another clock domain and changes rarely, so it is double-registered
//   and only accepted once it has held the same value for STABLE_CYC samples.
//   Conversion is sequential double-dabble (one shift per clock), followed by
//   a single commit cycle that updates the outputs and pulses bcd_valid.
// Ports:
//   clk_fx  block clock
//   rst_n   asynchronous active-low reset, resets every flop
//   bus     slave side of freq_bcd_convert_if (data_fx in; bcd_out,
//           digit_cnt, bcd_valid, busy out)
module freq_bcd_convert #(
  parameter int DW         = 20,
  parameter int DIGITS     = 7,
  parameter int STABLE_CYC = 4
) (
  input  logic                 clk_fx,
  input  logic                 rst_n,
  freq_bcd_convert_if.slave    bus
);

  localparam int BW  = 4 * DIGITS;
  localparam int SCW = $clog2(STABLE_CYC + 1);
  localparam int IW  = $clog2(DW + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Double-dabble correction: every nibble >= 5 gets +3 inside its own 4-bit
  // field. A corrected nibble is at most 12, so no carry can ever be needed.
  function automatic logic [BW-1:0] add3_nibbles(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = a;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Index of the highest nonzero digit plus one; an all-zero value still
  // shows one digit.
  function automatic logic [2:0] sig_digits(input logic [BW-1:0] a);
    logic [2:0] n;
    n = 3'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] != 4'd0) n = 3'(i + 1);
    end
    return n;
  endfunction

  logic [DW-1:0]  s1_q, s2_q;
  logic [SCW-1:0] stab_q, stab_d;
  logic [1:0]     state_q, state_d;
  logic [DW-1:0]  bin_q, bin_d;
  logic [BW-1:0]  acc_q, acc_d;
  logic [IW-1:0]  iter_q, iter_d;
  logic [DW-1:0]  last_q, last_d;
  logic [BW-1:0]  bcd_q, bcd_d;
  logic [2:0]     dcnt_q, dcnt_d;
  logic           vld_q, vld_d;
  logic           busy_q, busy_d;
  logic           stable;
  logic [BW-1:0]  acc_adj;

  // ---- Stage: input synchroniser and stability filter ----
  always_ff @(posedge clk_fx or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      stab_q <= '0;
    end else begin
      s1_q   <= bus.data_fx;
      s2_q   <= s1_q;
      stab_q <= stab_d;
    end
  end

  always_comb begin
    stab_d = '0;
    if (s1_q == s2_q) begin
      stab_d = (stab_q == SCW'(STABLE_CYC)) ? stab_q : stab_q + 1'b1;
    end
  end

  assign stable  = (stab_q == SCW'(STABLE_CYC));
  assign acc_adj = add3_nibbles(acc_q);

  // ---- Stage: conversion FSM and output commit ----
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    last_d  = last_q;
    bcd_d   = bcd_q;
    dcnt_d  = dcnt_q;
    vld_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        // A value equal to the last converted one never retriggers, so an
        // input of 0 straight after reset leaves the reset readout alone.
        if (stable && (s2_q != last_q)) begin
          bin_d   = s2_q;
          last_d  = s2_q;
          acc_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d  = {acc_adj[BW-2:0], bin_q[DW-1]};
        bin_d  = {bin_q[DW-2:0], 1'b0};
        iter_d = iter_q + 1'b1;
        if (iter_q == IW'(DW - 1)) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        // Outputs only ever change here, so partial results are never visible.
        bcd_d   = acc_q;
        dcnt_d  = sig_digits(acc_q);
        vld_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_fx or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
      last_q  <= '0;
      bcd_q   <= '0;
      dcnt_q  <= 3'd1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
      last_q  <= last_d;
      bcd_q   <= bcd_d;
      dcnt_q  <= dcnt_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.bcd_out   = bcd_q;
  assign bus.digit_cnt = dcnt_q;
  assign bus.bcd_valid = vld_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_freq_bcd_convert.sv
module tb_freq_bcd_convert;

  localparam int DW = 20;
  localparam int DIGITS = 7;

  logic clk_fx = 1'b0;
  logic rst_n  = 1'b0;

  freq_bcd_convert_if #(.DW(DW), .DIGITS(DIGITS)) bus ();

  freq_bcd_convert #(.DW(DW), .DIGITS(DIGITS), .STABLE_CYC(4)) dut (
    .clk_fx (clk_fx),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_fx = ~clk_fx;

  int n_chk  = 0;
  int n_fail = 0;

  // Observation monitor: counts loads (busy rising) and valid pulses,
  // captures the readout at each pulse and the load-to-valid distance.
  int   cyc = 0;
  int   t_load = 0;
  int   n_load = 0;
  int   vld_cnt = 0;
  int   cap_lat = 0;
  logic prev_busy = 1'b0;
  logic [31:0] cap_bcd = '0;
  logic [2:0]  cap_dc = '0;
  logic        cap_busy = 1'b0;

  always @(negedge clk_fx) begin
    cyc <= cyc + 1;
    prev_busy <= bus.busy;
    if (bus.busy && !prev_busy) begin
      t_load <= cyc;
      n_load <= n_load + 1;
    end
    if (bus.bcd_valid) begin
      vld_cnt  <= vld_cnt + 1;
      cap_bcd  <= 32'(bus.bcd_out);
      cap_dc   <= bus.digit_cnt;
      cap_busy <= bus.busy;
      cap_lat  <= cyc - t_load;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_load(input string tag);
    int n0;
    n0 = n_load;
    for (int i = 0; i < 60 && n_load == n0; i++) begin
      @(negedge clk_fx); #1;
    end
    check({tag, "_load_seen"}, 32'(n_load != n0), 32'd1);
  endtask

  task automatic expect_conv(input string tag, input logic [31:0] ebcd, input logic [2:0] edc);
    int n0;
    n0 = vld_cnt;
    for (int i = 0; i < 100 && vld_cnt == n0; i++) begin
      @(negedge clk_fx); #1;
    end
    check({tag, "_valid_seen"}, 32'(vld_cnt != n0), 32'd1);
    check({tag, "_bcd"}, cap_bcd, ebcd);
    check({tag, "_digits"}, 32'(cap_dc), 32'(edc));
    check({tag, "_latency"}, 32'(cap_lat), 32'd21);
    check({tag, "_busy_at_valid"}, 32'(cap_busy), 32'd0);
    @(negedge clk_fx); #1;
    check({tag, "_valid_one_cycle"}, 32'(bus.bcd_valid), 32'd0);
    check({tag, "_bcd_hold"}, 32'(bus.bcd_out), ebcd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, nl;
    bus.data_fx = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_fx);
    #1;
    check("rst_bcd", 32'(bus.bcd_out), 32'h0);
    check("rst_digits", 32'(bus.digit_cnt), 32'd1);
    check("rst_valid", 32'(bus.bcd_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk_fx);
    rst_n = 1'b1;

    // 1: zero input after reset never triggers a conversion
    repeat (50) @(negedge clk_fx);
    #1;
    check("t1_no_valid", 32'(vld_cnt), 32'd0);
    check("t1_no_load", 32'(n_load), 32'd0);
    check("t1_bcd", 32'(bus.bcd_out), 32'h0);
    check("t1_digits", 32'(bus.digit_cnt), 32'd1);
    check("t1_busy", 32'(bus.busy), 32'd0);

    // 2: 12345, then hold and confirm no retrigger
    bus.data_fx = 20'd12345;
    expect_conv("t2", 32'h0012345, 3'd5);
    nv = vld_cnt; nl = n_load;
    repeat (40) @(negedge clk_fx);
    #1;
    check("t2_no_repeat_valid", 32'(vld_cnt), 32'(nv));
    check("t2_no_repeat_load", 32'(n_load), 32'(nl));

    // 3: full-scale input, then a single digit
    bus.data_fx = 20'd1048575;
    expect_conv("t3_max", 32'h1048575, 3'd7);
    bus.data_fx = 20'd7;
    expect_conv("t3_seven", 32'h0000007, 3'd1);

    // 4: input toggling every 2 cycles is never accepted
    nl = n_load;
    for (int i = 0; i < 20; i++) begin
      bus.data_fx = (i % 2 == 0) ? 20'd100 : 20'd200;
      repeat (2) @(negedge clk_fx);
    end
    #1;
    check("t4_no_load_toggle", 32'(n_load), 32'(nl));
    bus.data_fx = 20'd200;
    expect_conv("t4", 32'h0000200, 3'd3);

    // 5: input change mid-conversion does not abort it
    bus.data_fx = 20'd500000;
    wait_load("t5");
    repeat (5) @(posedge clk_fx);
    #1;
    bus.data_fx = 20'd999;
    expect_conv("t5_first", 32'h0500000, 3'd6);
    expect_conv("t5_second", 32'h0000999, 3'd3);

    // 6: reset in the middle of a conversion
    bus.data_fx = 20'd65535;
    wait_load("t6");
    repeat (10) @(posedge clk_fx);
    #1;
    nv = vld_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_rst_bcd", 32'(bus.bcd_out), 32'h0);
    check("t6_rst_digits", 32'(bus.digit_cnt), 32'd1);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_valid", 32'(bus.bcd_valid), 32'd0);
    repeat (15) @(negedge clk_fx);
    #1;
    check("t6_no_valid_in_rst", 32'(vld_cnt), 32'(nv));
    rst_n = 1'b1;
    expect_conv("t6_after", 32'h0065535, 3'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
